alu_rr_sched: RTL and testbench
===============================

# alu_rr_sched

Round-robin scheduler that shares one 8-bit ALU between NREQ independent requesters. Each requester presents an operation (ctrl, x, y) with a valid/ready handshake. The scheduler grants one requester per cycle, drives the shared ALU, and captures the result in a one-entry output register. The result leaves through a valid/ready response port tagged with the requester ID. The block sits between the instruction-issue logic and the ALU datapath.

## Interface
- NREQ, 4: number of requesters (2..4); requester ID width IDW = 2.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  requester i holds an operation
- req_ready  out  NREQ  operation of requester i accepted this cycle (one-hot or zero)
- req_ctrl  in  4*NREQ  opcode of requester i at bits [4i+3:4i]
- req_x  in  8*NREQ  operand x of requester i at bits [8i+7:8i]
- req_y  in  8*NREQ  operand y of requester i at bits [8i+7:8i]
- rsp_valid  out  1  result register holds a result
- rsp_ready  in  1  consumer takes the result this cycle
- rsp_id  out  IDW  requester ID of the held result
- rsp_out  out  8  ALU result
- rsp_carry  out  1  ALU carry
- illegal_cnt  out  16  saturating count of accepted operations with ctrl ≥ 4'hD

## Operation
- FSM has two states.
  - EMPTY: rsp_valid = 0.
  - FULL: rsp_valid = 1.
- can_accept = (state == EMPTY) || rsp_ready.
- Arbitration is round-robin over requesters with req_valid = 1.
  - The search starts at ptr + 1 mod NREQ.
  - ptr is the index of the last granted requester.
  - The winner g gets req_ready[g] = can_accept. All other req_ready bits are 0.
- Transfer: an accept happens when req_valid[g] && req_ready[g]. On accept:
  - The winner's ctrl, x and y drive the combinational ALU.
  - {rsp_carry, rsp_out, rsp_id} ← {ALU carry, ALU out, g}.
  - ptr ← g.
  - State becomes FULL.
- Drain without accept: rsp_ready && FULL with no accept → EMPTY.
- Simultaneous drain and accept: FULL stays FULL. New data replaces old data in the same cycle, so there is no bubble.
- When no request is accepted, ptr holds.
- Opcode semantics (ALU, 8-bit):
  - 0: {carry,out} = 9-bit sign-extended x + y.
  - 1: {carry,out} = 9-bit sign-extended x − y.
  - 2: AND. 3: OR. 4: ~x. 5: XOR. 6: NOR.
  - 7: y << x[2:0]. 8: y >> x[2:0].
  - 9: arithmetic shift right of x by 1. A: rotate left x. B: rotate right x.
  - C: out = (x == y) zero-extended.
  - D–F: out = 0.
  - carry = 0 for every opcode except 0 and 1.
- illegal_cnt increments by 1 on every accept with ctrl ≥ 4'hD. It saturates at 16'hFFFF.
- Response outputs are stable while rsp_valid && !rsp_ready.

## Timing
- Reset values:
  - state = EMPTY, rsp_valid = 0, rsp_id = 0, rsp_out = 0, rsp_carry = 0.
  - ptr = NREQ−1, so requester 0 has first priority.
  - illegal_cnt = 0, req_ready = 0.
- Reset asserted mid-operation discards a held result immediately and asynchronously. No response is produced for it.
- Latency is 1 cycle: an accept at edge N gives rsp_valid = 1 with the result after edge N.
- Throughput is 1 op/cycle while rsp_ready = 1.
- req_ready is combinational from req_valid, rsp_ready, state and ptr. There is no path from req_ctrl, req_x or req_y to req_ready.
- Requesters must hold ctrl, x and y stable while valid && !ready. A valid request is never starved: it waits at most NREQ−1 grants.

## Structure
- Shared package alu_pkg:
  - Opcode localparams OP_ADD … OP_EQ (4'h0–4'hC).
  - OP_ILLEGAL_MIN = 4'hD.
  - Widths DW = 8, CW = 4.
- Sub-module alu_core holds the combinational 8-bit ALU, with ports ctrl, x, y, carry, out. The scheduler instantiates it once.
- The round-robin search is a function inside alu_rr_sched.

## Test plan
- Reset then req_valid = 4'b0001, req0 = {0, 8'h80, 8'h80} → req_ready = 4'b0001. Next cycle rsp_valid = 1, rsp_id = 0, carry = 1, out = 8'h00.
- All four valid, rsp_ready = 1 constantly → grants in order 0, 1, 2, 3, 0, … on consecutive cycles. rsp_id follows one cycle later with no bubbles.
- Backpressure: FULL with rsp_ready = 0 for 5 cycles → req_ready = 0 and response outputs unchanged. Raise rsp_ready → the next request is accepted in the same cycle and FULL persists.
- req1 = {1, 8'h00, 8'h01} → rsp_id = 1, carry = 1, out = 8'hFF. Then req1 = {0, 8'hFF, 8'h01} → carry = 0, out = 8'h00.
- req2 = {4'hE, 8'h55, 8'hAA} → out = 0, carry = 0, illegal_cnt 0 → 1. Forced illegal_cnt = 16'hFFFF plus another illegal op → stays 16'hFFFF.
- Assert rst while FULL with requests pending → rsp_valid = 0 and req_ready = 0 immediately. After release, requester 0 wins first.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the round-robin ALU scheduler and its ALU core:
// datapath widths, opcode encodings, the response FSM state type and the
// packed records used to carry a grant decision and a held result.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DW  = 8;   // ALU data width
    localparam int CW  = 4;   // opcode width
    localparam int IDW = 2;   // requester ID width

    localparam logic [CW-1:0] OP_ADD = 4'h0;
    localparam logic [CW-1:0] OP_SUB = 4'h1;
    localparam logic [CW-1:0] OP_AND = 4'h2;
    localparam logic [CW-1:0] OP_OR  = 4'h3;
    localparam logic [CW-1:0] OP_NOT = 4'h4;
    localparam logic [CW-1:0] OP_XOR = 4'h5;
    localparam logic [CW-1:0] OP_NOR = 4'h6;
    localparam logic [CW-1:0] OP_SHL = 4'h7;
    localparam logic [CW-1:0] OP_SHR = 4'h8;
    localparam logic [CW-1:0] OP_ASR = 4'h9;
    localparam logic [CW-1:0] OP_ROL = 4'hA;
    localparam logic [CW-1:0] OP_ROR = 4'hB;
    localparam logic [CW-1:0] OP_EQ  = 4'hC;

    // Every opcode at or above this value is unassigned and counted as illegal.
    localparam logic [CW-1:0] OP_ILLEGAL_MIN = 4'hD;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Result held in the one-entry output register.
    typedef struct packed {
        logic           carry;
        logic [DW-1:0]  out;
        logic [IDW-1:0] id;
    } rsp_t;

    // Outcome of the round-robin search.
    typedef struct packed {
        logic           found;
        logic [IDW-1:0] idx;
    } pick_t;

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational 8-bit ALU shared by all requesters.
// Ports:
//   ctrl  in  CW  opcode
//   x     in  DW  operand x
//   y     in  DW  operand y
//   carry out 1   carry / borrow (add and subtract only)
//   out   out DW  result
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
(
    input  logic [CW-1:0] ctrl,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    output logic          carry,
    output logic [DW-1:0] out
);

    // Add and subtract operate on sign-extended operands, so the 9th bit is
    // the sign of the true result rather than an unsigned carry.
    logic [DW:0] sum;
    logic [DW:0] diff;

    assign sum  = {x[DW-1], x} + {y[DW-1], y};
    assign diff = {x[DW-1], x} - {y[DW-1], y};

    // NOTE: every output gets a default before the case so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        carry = 1'b0;
        out   = '0;
        case (ctrl)
            OP_ADD:  {carry, out} = sum;
            OP_SUB:  {carry, out} = diff;
            OP_AND:  out = x & y;
            OP_OR:   out = x | y;
            OP_NOT:  out = ~x;
            OP_XOR:  out = x ^ y;
            OP_NOR:  out = ~(x | y);
            OP_SHL:  out = y << x[2:0];
            OP_SHR:  out = y >> x[2:0];
            OP_ASR:  out = {x[DW-1], x[DW-1:1]};
            OP_ROL:  out = {x[DW-2:0], x[DW-1]};
            OP_ROR:  out = {x[0], x[DW-1:1]};
            OP_EQ:   out = {{(DW-1){1'b0}}, (x == y)};
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_sched.sv
// -----------------------------------------------------------------------------
// alu_rr_sched
// Round-robin scheduler sharing one ALU between NREQ requesters. One request
// is granted per cycle, executed on the shared ALU and captured in a
// one-entry response register tagged with the requester ID.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req_valid     per-requester operation valid
//   req_ready     per-requester accept (one-hot or zero)
//   req_ctrl      packed opcodes, requester i at [4i+3:4i]
//   req_x, req_y  packed operands, requester i at [8i+7:8i]
//   rsp_valid     response register holds a result
//   rsp_ready     consumer takes the result this cycle
//   rsp_id        requester ID of the held result
//   rsp_out       ALU result
//   rsp_carry     ALU carry
//   illegal_cnt   saturating count of accepted illegal opcodes
// -----------------------------------------------------------------------------
module alu_rr_sched
    import alu_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [CW*NREQ-1:0] req_ctrl,
    input  logic [DW*NREQ-1:0] req_x,
    input  logic [DW*NREQ-1:0] req_y,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [DW-1:0]      rsp_out,
    output logic               rsp_carry,
    output logic [15:0]        illegal_cnt
);

    // Search the valid vector starting just after the last winner.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] valid,
                                      input logic [IDW-1:0]  last);
        pick_t           r;
        logic [NREQ-1:0] sh;
        int              j;
        r = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j  = (int'(last) + k) % NREQ;
            sh = valid >> j;
            if (!r.found && sh[0]) begin
                r.found = 1'b1;
                r.idx   = IDW'(j);
            end
        end
        return r;
    endfunction

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    rsp_t           rsp_q, rsp_d;
    logic [15:0]    illegal_cnt_q, illegal_cnt_d;

    pick_t          pick;
    logic           can_accept;
    logic           accept;
    logic [CW-1:0]  alu_ctrl;
    logic [DW-1:0]  alu_x;
    logic [DW-1:0]  alu_y;
    logic           alu_carry;
    logic [DW-1:0]  alu_out;

    // Ready depends only on valids, state, pointer and rsp_ready; the
    // operands never feed back into the handshake. Reset forces it low.
    assign pick       = rr_pick(req_valid, ptr_q);
    assign can_accept = (state_q == ST_EMPTY) || rsp_ready;
    assign req_ready  = (pick.found && can_accept && !rst) ? (NREQ'(1) << pick.idx) : '0;
    assign accept     = |(req_valid & req_ready);

    // Steer the winner's operation into the shared ALU.
    assign alu_ctrl = CW'(req_ctrl >> (CW * int'(pick.idx)));
    assign alu_x    = DW'(req_x    >> (DW * int'(pick.idx)));
    assign alu_y    = DW'(req_y    >> (DW * int'(pick.idx)));

    alu_core u_alu_core (
        .ctrl  (alu_ctrl),
        .x     (alu_x),
        .y     (alu_y),
        .carry (alu_carry),
        .out   (alu_out)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        rsp_d         = rsp_q;
        illegal_cnt_d = illegal_cnt_q;
        if (accept) begin
            // An accept overwrites the register even when it is being drained
            // in the same cycle, so back-to-back results have no bubble.
            state_d = ST_FULL;
            ptr_d   = pick.idx;
            rsp_d   = '{carry: alu_carry, out: alu_out, id: pick.idx};
            if (alu_ctrl >= OP_ILLEGAL_MIN && illegal_cnt_q != 16'hFFFF)
                illegal_cnt_d = illegal_cnt_q + 16'd1;
        end else if (state_q == ST_FULL && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_EMPTY;
            ptr_q         <= IDW'(NREQ - 1);
            rsp_q         <= '0;
            illegal_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            rsp_q         <= rsp_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign rsp_valid   = (state_q == ST_FULL);
    assign rsp_id      = rsp_q.id;
    assign rsp_out     = rsp_q.out;
    assign rsp_carry   = rsp_q.carry;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_sched
// Self-checking bench for alu_rr_sched: directed scenarios followed by a
// randomized phase, all compared against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_alu_rr_sched;

    localparam int N = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [4*N-1:0] req_ctrl;
    logic [8*N-1:0] req_x;
    logic [8*N-1:0] req_y;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [7:0]    rsp_out;
    logic          rsp_carry;
    logic [15:0]   illegal_cnt;

    alu_rr_sched #(.NREQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_ctrl    (req_ctrl),
        .req_x       (req_x),
        .req_y       (req_y),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_out     (rsp_out),
        .rsp_carry   (rsp_carry),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic       m_full;
    int         m_id;
    logic [7:0] m_out;
    logic       m_carry;
    int         m_last;
    int         m_ill;
    int         last_g;   // requester the model expects to be accepted, -1 if none

    // ALU behaviour computed with integer arithmetic; returns {carry, out}.
    function automatic logic [8:0] ref_alu(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
        int ux, uy, sx, sy, r;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 128) ? ux - 256 : ux;
        sy = (uy >= 128) ? uy - 256 : uy;
        case (c)
            4'h0: return 9'(sx + sy);
            4'h1: return 9'(sx - sy);
            4'h2: r = ux & uy;
            4'h3: r = ux | uy;
            4'h4: r = 255 - ux;
            4'h5: r = ux ^ uy;
            4'h6: r = 255 - (ux | uy);
            4'h7: r = uy * (1 << (ux % 8));
            4'h8: r = uy / (1 << (ux % 8));
            4'h9: r = (sx < 0) ? (sx - 1) / 2 : sx / 2;
            4'hA: r = ux * 2 + ux / 128;
            4'hB: r = ux / 2 + (ux % 2) * 128;
            4'hC: r = (ux == uy) ? 1 : 0;
            default: r = 0;
        endcase
        return {1'b0, 8'(r & 255)};
    endfunction

    // First valid requester after 'last' in circular order, -1 if none.
    function automatic int ref_pick(input logic [N-1:0] v, input int last);
        int res;
        res = -1;
        for (int k = 1; k <= N; k++)
            if (res < 0 && v[(last + k) % N]) res = (last + k) % N;
        return res;
    endfunction

    task automatic model_reset();
        m_full  = 1'b0;
        m_id    = 0;
        m_out   = 8'h00;
        m_carry = 1'b0;
        m_last  = N - 1;
        m_ill   = 0;
    endtask

    task automatic set_req(input int i, input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
        req_ctrl[4*i +: 4] = c;
        req_x[8*i +: 8]    = x;
        req_y[8*i +: 8]    = y;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    endtask

    // One clock cycle: entered just after a falling edge with inputs driven,
    // returns at the next falling edge.
    task automatic cycle();
        logic       can;
        int         g;
        logic [3:0] exp_rdy;
        logic [8:0] res;
        #1;
        can     = !m_full || rsp_ready;
        g       = ref_pick(req_valid, m_last);
        exp_rdy = (g >= 0 && can) ? 4'(1 << g) : 4'b0000;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        last_g  = (exp_rdy != 0) ? g : -1;
        @(posedge clk);
        if (last_g >= 0) begin
            res     = ref_alu(req_ctrl[4*g +: 4], req_x[8*g +: 8], req_y[8*g +: 8]);
            m_full  = 1'b1;
            m_id    = g;
            m_carry = res[8];
            m_out   = res[7:0];
            m_last  = g;
            if (req_ctrl[4*g +: 4] >= 4'hD && m_ill < 65535) m_ill++;
        end else if (m_full && rsp_ready) begin
            m_full = 1'b0;
        end
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (m_full) begin
            check("rsp_id",    32'(rsp_id),    32'(m_id));
            check("rsp_out",   32'(rsp_out),   32'(m_out));
            check("rsp_carry", 32'(rsp_carry), 32'(m_carry));
        end
        check("illegal_cnt", 32'(illegal_cnt), 32'(m_ill));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_ctrl  = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b0;
        last_g    = -1;
        model_reset();
        do_reset();

        // Reset values
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id",    32'(rsp_id),    0);
        check("rst_rsp_out",   32'(rsp_out),   0);
        check("rst_rsp_carry", 32'(rsp_carry), 0);
        check("rst_illegal",   32'(illegal_cnt), 0);
        check("rst_req_ready", 32'(req_ready), 0);

        // Signed add overflow: 0x80 + 0x80
        req_valid = 4'b0001;
        set_req(0, 4'h0, 8'h80, 8'h80);
        cycle();
        check("add_id",    32'(rsp_id),    0);
        check("add_carry", 32'(rsp_carry), 1);
        check("add_out",   32'(rsp_out),   32'h00);

        // Round-robin fairness with continuous drain
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) rand_req(i);
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("rr_ready_seq", 32'(dut.req_ready == 0 ? 0 : 1), 32'(1)) ;
            check("rr_rsp_id",    32'(rsp_id),    32'(k % N));
            check("rr_rsp_valid", 32'(rsp_valid), 1);
            if (last_g >= 0) rand_req(last_g);
        end

        // Backpressure: held result must not move, no accepts
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("bp_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        cycle();
        check("bp_resume_valid", 32'(rsp_valid), 1);

        // Subtract borrow, then add wrapping to zero
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        set_req(1, 4'h1, 8'h00, 8'h01);
        cycle();
        check("sub_id",    32'(rsp_id),    1);
        check("sub_carry", 32'(rsp_carry), 1);
        check("sub_out",   32'(rsp_out),   32'hFF);
        set_req(1, 4'h0, 8'hFF, 8'h01);
        cycle();
        check("add2_carry", 32'(rsp_carry), 0);
        check("add2_out",   32'(rsp_out),   32'h00);

        // Illegal opcode counting and saturation
        req_valid = 4'b0100;
        set_req(2, 4'hE, 8'h55, 8'hAA);
        cycle();
        check("ill_out",   32'(rsp_out),     0);
        check("ill_carry", 32'(rsp_carry),   0);
        check("ill_cnt1",  32'(illegal_cnt), 1);
        req_valid = 4'b0000;
        force dut.illegal_cnt_q = 16'hFFFF;
        m_ill = 65535;
        cycle();
        release dut.illegal_cnt_q;
        req_valid = 4'b0100;
        set_req(2, 4'hF, 8'h12, 8'h34);
        cycle();
        check("ill_sat", 32'(illegal_cnt), 32'hFFFF);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    rand_req(i);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (last_g >= 0) req_valid[last_g] = 1'b0;
        end

        // Asynchronous reset while holding a result with requests pending
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) rand_req(i);
        rsp_ready = 1'b0;
        cycle();
        check("pre_rst_valid", 32'(rsp_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(rsp_valid), 0);
        check("async_rst_ready", 32'(req_ready), 0);
        model_reset();
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        cycle();
        check("post_rst_id", 32'(rsp_id), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
